// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the ICache refill path.
package icache_pkg;

  localparam int LINE_BEATS = 4;  // 32-bit beats per 128-bit cached line
  localparam int UNC_BEATS  = 2;  // 32-bit beats per 64-bit uncached fetch packet
  localparam int LINE_OFF_W = 4;
  localparam int WORD_OFF_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DRAIN,
    ST_DONE
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Miss-request, flush, AXI read-channel and return-buffer signals of the refill controller.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_uncache;
  logic [ADDR_W-1:0] req_paddr;
  logic              req_ready;
  logic              flush;
  logic              i_arvalid;
  logic              i_arready;
  logic [ADDR_W-1:0] i_araddr;
  logic [7:0]        i_arlen;
  logic              i_rvalid;
  logic              i_rlast;
  logic              i_rready;
  logic              rb_shift;
  logic              uncache_pipe;
  logic              refill_we;
  logic              refill_done;
  logic              beat_err;

  // The refill controller itself.
  modport slave (
    input  req_valid, req_uncache, req_paddr, flush, i_arready, i_rvalid, i_rlast,
    output req_ready, i_arvalid, i_araddr, i_arlen, i_rready, rb_shift,
           uncache_pipe, refill_we, refill_done, beat_err
  );

  // Miss stage plus AXI read slave surrounding the controller.
  modport master (
    output req_valid, req_uncache, req_paddr, flush, i_arready, i_rvalid, i_rlast,
    input  req_ready, i_arvalid, i_araddr, i_arlen, i_rready, rb_shift,
           uncache_pipe, refill_we, refill_done, beat_err
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// ICache refill sequencer: one AXI read burst per miss, beat counting, refill/done pulses.
module icache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BEATS = icache_pkg::LINE_BEATS,
  parameter int UNC_BEATS  = icache_pkg::UNC_BEATS
) (
  input logic                 clk,
  input logic                 rst,
  icache_refill_ctrl_if.slave bus
);

  import icache_pkg::*;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFF_W) - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << WORD_OFF_W) - 1);

  refill_state_e     state_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              unc_q;
  logic              done_q;
  logic              err_q;
  logic              flush_pend_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] araddr_d;
  logic [7:0]        arlen_q;
  logic [7:0]        arlen_d;
  logic              beat;

  always_comb begin
    araddr_d = bus.req_paddr & (bus.req_uncache ? WORD_MASK : LINE_MASK);
    arlen_d  = bus.req_uncache ? 8'(UNC_BEATS - 1) : 8'(LINE_BEATS - 1);
  end

  assign beat = bus.i_rvalid & rready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      unc_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= 2'd0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            unc_q        <= bus.req_uncache;
            cnt_q        <= 2'd0;
            flush_pend_q <= 1'b0;
            arvalid_q    <= 1'b1;
            state_q      <= ST_AR;
          end
        end
        ST_AR: begin
          // The address must go out even if the miss is flushed; the burst is then drained.
          if (bus.flush) flush_pend_q <= 1'b1;
          if (bus.i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (flush_pend_q || bus.flush) ? ST_DRAIN : ST_R;
          end
        end
        ST_R: begin
          if (beat) cnt_q <= cnt_q + 2'd1;
          if (beat && bus.i_rlast) begin
            if (cnt_q != arlen_q[1:0]) err_q <= 1'b1;
            rready_q <= 1'b0;
            if (bus.flush) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else if (bus.flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (beat && bus.i_rlast) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.i_arvalid    = arvalid_q;
  assign bus.i_araddr     = araddr_q;
  assign bus.i_arlen      = arlen_q;
  assign bus.i_rready     = rready_q;
  assign bus.rb_shift     = beat;
  assign bus.uncache_pipe = unc_q;
  assign bus.beat_err     = err_q;
  // A flush landing on the completion cycle cancels the writeback and the done indication.
  assign bus.refill_done  = done_q & ~bus.flush;
  assign bus.refill_we    = done_q & ~unc_q & ~bus.flush;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus randomized traffic against a miss-level model.
module tb_icache_refill_ctrl;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(AW)) bus ();

  icache_refill_ctrl #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (one outstanding miss) ----------------
  bit          m_busy, m_ar, m_rph, m_flushed, m_done, m_unc, m_err;
  int          m_beats, m_len;
  logic [31:0] m_addr;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_ar = 0; m_rph = 0; m_flushed = 0; m_done = 0;
      m_unc = 0; m_err = 0; m_beats = 0; m_len = 0; m_addr = '0;
    end
    chk("cmp req_ready",   bus.req_ready,    !m_busy);
    chk("cmp arvalid",     bus.i_arvalid,    m_busy && m_ar);
    chk("cmp rready",      bus.i_rready,     m_busy && m_rph);
    chk("cmp rb_shift",    bus.rb_shift,     m_busy && m_rph && bus.i_rvalid);
    chk("cmp refill_done", bus.refill_done,  m_done && !bus.flush);
    chk("cmp refill_we",   bus.refill_we,    m_done && !bus.flush && !m_unc);
    chk("cmp araddr",      bus.i_araddr,     m_addr);
    chk("cmp arlen",       bus.i_arlen,      m_len);
    chk("cmp uncache",     bus.uncache_pipe, m_unc);
    chk("cmp beat_err",    bus.beat_err,     m_err);
    if (!rst) begin
      if (!m_busy) begin
        if (bus.req_valid && !bus.flush) begin
          m_busy = 1; m_ar = 1; m_rph = 0; m_flushed = 0; m_done = 0; m_beats = 0;
          m_unc  = bus.req_uncache;
          m_addr = bus.req_paddr & (m_unc ? ~32'h3 : ~32'hF);
          m_len  = m_unc ? 1 : 3;
        end
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_ar) begin
        if (bus.flush) m_flushed = 1;
        if (bus.i_arready) begin m_ar = 0; m_rph = 1; end
      end else if (m_rph) begin
        if (bus.i_rvalid && bus.i_rlast) begin
          if (!m_flushed && m_beats != m_len) m_err = 1;
          m_rph = 0;
          if (m_flushed || bus.flush) m_busy = 0;
          else m_done = 1;
        end else begin
          if (bus.i_rvalid && !m_flushed) m_beats++;
          if (bus.flush) m_flushed = 1;
        end
      end
    end
  end

  // ---------------- AXI read slave and cycle stepping ----------------
  int   s_pend  = 0;
  bit   s_early = 0;
  int   rv_pct  = 100;
  logic s_req_ready, s_arvalid, s_shift, s_we, s_done, s_unc, s_err;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;

  task automatic tick();
    bit ar_hs, r_hs;
    @(negedge clk);
    ar_hs       = bus.i_arvalid && bus.i_arready;
    r_hs        = bus.i_rvalid && bus.i_rready;
    s_req_ready = bus.req_ready;
    s_arvalid   = bus.i_arvalid;
    s_shift     = bus.rb_shift;
    s_we        = bus.refill_we;
    s_done      = bus.refill_done;
    s_unc       = bus.uncache_pipe;
    s_err       = bus.beat_err;
    s_araddr    = bus.i_araddr;
    s_arlen     = bus.i_arlen;
    @(posedge clk);
    #1;
    if (rst) begin
      s_pend = 0;
    end else begin
      if (r_hs && s_pend > 0) s_pend--;
      if (ar_hs) begin
        s_pend  = (s_early && bus.i_arlen == 8'd3) ? 2 : int'(bus.i_arlen) + 1;
        s_early = 0;
      end
    end
    bus.i_rvalid = (s_pend > 0) && ($urandom_range(99) < rv_pct);
    bus.i_rlast  = (s_pend == 1);
  endtask

  // Issue one request and run until the controller is idle again.
  task automatic run_req(input logic [31:0] pa, input bit unc,
                         output int dones, output int wes, output int shifts, output bit ok);
    dones = 0; wes = 0; shifts = 0; ok = 0;
    bus.req_valid = 1; bus.req_uncache = unc; bus.req_paddr = pa;
    tick();
    bus.req_valid = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      dones  += int'(s_done);
      wes    += int'(s_we);
      shifts += int'(s_shift);
      if (s_req_ready) begin ok = 1; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d, w, sh, pulses;
    bit  ok, saw_last;
    bus.req_valid = 0; bus.req_uncache = 0; bus.req_paddr = '0; bus.flush = 0;
    bus.i_arready = 0; bus.i_rvalid = 0; bus.i_rlast = 0;

    // Reset state
    tick(); tick();
    chk("rst arvalid", s_arvalid, 0);
    chk("rst araddr",  s_araddr, 0);
    chk("rst arlen",   s_arlen, 0);
    chk("rst err",     s_err, 0);
    chk("rst unc",     s_unc, 0);
    rst = 0;
    tick();

    // Cached miss, zero-wait slave
    bus.i_arready = 1;
    bus.req_valid = 1; bus.req_uncache = 0; bus.req_paddr = 32'h1C00_0014;
    tick();
    chk("t1 accept", s_req_ready, 1);
    bus.req_valid = 0;
    tick();
    chk("t1 arvalid", s_arvalid, 1);
    chk("t1 araddr",  s_araddr, 32'h1C00_0010);
    chk("t1 arlen",   s_arlen, 3);
    chk("t1 no shift c1", s_shift, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("t1 shift", s_shift, 1);
      chk("t1 no done", s_done, 0);
    end
    tick();
    chk("t1 refill_we",   s_we, 1);
    chk("t1 refill_done", s_done, 1);
    chk("t1 beat_err",    s_err, 0);
    tick();
    chk("t1 idle after", s_req_ready, 1);

    // Uncached miss
    bus.req_valid = 1; bus.req_uncache = 1; bus.req_paddr = 32'h1FD0_0008;
    tick();
    bus.req_valid = 0;
    tick();
    chk("t2 araddr", s_araddr, 32'h1FD0_0008);
    chk("t2 arlen",  s_arlen, 1);
    tick(); chk("t2 shift c2", s_shift, 1);
    tick(); chk("t2 shift c3", s_shift, 1);
    tick();
    chk("t2 done", s_done, 1);
    chk("t2 no we", s_we, 0);
    chk("t2 unc",  s_unc, 1);
    tick();
    chk("t2 unc held", s_unc, 1);

    // AR stalled, flush while waiting: address still issued, burst drained silently
    bus.i_arready = 0;
    bus.req_valid = 1; bus.req_uncache = 0; bus.req_paddr = 32'h0000_1234;
    tick();
    bus.req_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      bus.flush     = (c == 2);
      bus.i_arready = (c == 6);
      tick();
      chk("t3 arvalid held", s_arvalid, 1);
    end
    bus.flush = 0;
    pulses = 0; sh = 0; ok = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      pulses += int'(s_done) + int'(s_we);
      sh     += int'(s_shift);
      if (s_req_ready) begin ok = 1; break; end
    end
    chk("t3 ready", ok, 1);
    chk("t3 drained beats", sh, 4);
    chk("t3 no pulses", pulses, 0);

    // Flush together with the last beat
    bus.req_valid = 1; bus.req_uncache = 0; bus.req_paddr = 32'h0000_4000;
    tick();
    bus.req_valid = 0;
    d = 0; ok = 0; saw_last = 0; sh = 0;
    for (int n = 0; n < 20; n++) begin
      bus.flush = bus.i_rvalid && bus.i_rlast;
      if (bus.flush) saw_last = 1;
      tick();
      d  += int'(s_done) + int'(s_we);
      sh += int'(s_shift);
      if (s_req_ready) begin ok = 1; break; end
    end
    bus.flush = 0;
    tick();
    d += int'(s_done);
    chk("t4 ready", ok, 1);
    chk("t4 saw last", saw_last, 1);
    chk("t4 shifts", sh, 4);
    chk("t4 no done", d, 0);

    // Short burst sets the sticky error
    s_early = 1;
    run_req(32'h0000_8000, 0, d, w, sh, ok);
    chk("t5 ready", ok, 1);
    chk("t5 shifts", sh, 2);
    chk("t5 err", s_err, 1);
    run_req(32'h0000_9000, 0, d, w, sh, ok);
    chk("t5 clean done", d, 1);
    chk("t5 err sticky", s_err, 1);

    // Asynchronous reset in the middle of the data phase
    bus.req_valid = 1; bus.req_uncache = 0; bus.req_paddr = 32'h0000_A000;
    tick();
    bus.req_valid = 0;
    tick(); tick(); tick();
    rst = 1;
    #1;
    chk("t6 arvalid", bus.i_arvalid, 0);
    chk("t6 rready",  bus.i_rready, 0);
    chk("t6 shift",   bus.rb_shift, 0);
    chk("t6 we",      bus.refill_we, 0);
    chk("t6 done",    bus.refill_done, 0);
    chk("t6 unc",     bus.uncache_pipe, 0);
    chk("t6 err",     bus.beat_err, 0);
    chk("t6 araddr",  bus.i_araddr, 0);
    chk("t6 arlen",   bus.i_arlen, 0);
    tick();
    rst = 0;
    bus.req_valid = 1; bus.req_uncache = 1; bus.req_paddr = 32'h0000_B006;
    tick();
    chk("t6 accept", s_req_ready, 1);
    bus.req_valid = 0;
    tick();
    chk("t6 arvalid after", s_arvalid, 1);
    chk("t6 araddr after",  s_araddr, 32'h0000_B004);
    for (int n = 0; n < 10; n++) tick();

    // Randomized traffic
    rv_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid   = 1'($urandom_range(1));
      bus.req_uncache = 1'($urandom_range(1));
      bus.req_paddr   = $urandom;
      bus.flush       = ($urandom_range(15) == 0);
      bus.i_arready   = ($urandom_range(9) < 7);
      s_early         = ($urandom_range(7) == 0);
      rst             = ($urandom_range(499) == 0);
      tick();
    end
    rst = 0; bus.req_valid = 0; bus.flush = 0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
